// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART receiver peripheral:
//   - CPU I/O-space addresses of the UART registers
//   - UART_CON bit positions owned by the receiver
//   - receiver FSM state encoding
//   - oversampling divisor helper
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [31:0] UART_TXD = 32'h4000_0018;
    localparam logic [31:0] UART_RXD = 32'h4000_001C;
    localparam logic [31:0] UART_CON = 32'h4000_0020;

    localparam int CON_RX_INT_EN = 1;
    localparam int CON_RX_VALID  = 3;
    localparam int CON_FRAME_ERR = 4;
    localparam int CON_OVERRUN   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clocks per 16x oversampling tick, floored and never below one.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Generates a one-clock pulse every DIV clocks (16x the line rate) while en is
// high. The count is held at zero whenever en is low, so every new frame
// starts from a fresh tick phase.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   en    in  tick enable (receiver busy)
//   tick  out 16x oversampling pulse
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Divider counter, cleared while disabled so it restarts when en falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (!en) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_periph.sv
// -----------------------------------------------------------------------------
// uart_rx_periph
// Memory-mapped 8N1 UART receiver for the MIPS I/O space.
//   UART_RXD (0x4000_001C) RO : {24'b0, rx_data}; reading clears rx_valid
//   UART_CON (0x4000_0020) RW : bit1 rx_int_en, bit3 rx_valid (RO),
//                               bit4 frame_err (W1C), bit5 overrun (W1C)
// Ports:
//   clk, reset (async active-low), uart_rxd (async serial in, idles high),
//   addr/rd/wr/wdata (CPU bus), rdata (combinational read data),
//   irq (rx_valid & rx_int_en)
// -----------------------------------------------------------------------------
module uart_rx_periph
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rxd,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [1:0] r_sync;
    rx_state_t  r_state;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_frame_err;
    logic       r_overrun;
    logic       r_rx_int_en;

    logic w_line;
    logic w_tick;
    logic w_tick_en;
    logic w_stop_sample;
    logic w_byte_ok;
    logic w_byte_bad;
    logic w_rd_rxd;
    logic w_wr_con;
    logic w_ovr_set;
    logic w_unused;

    assign w_line    = r_sync[1];
    assign w_tick_en = (r_state != IDLE);

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick_en),
        .tick  (w_tick)
    );

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
        end
    end

    // Receive FSM: start detect, mid-bit sampling of 8 data bits, stop bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_line) begin
                        r_state    <= START;
                        r_tick_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7) begin
                            r_tick_cnt <= 4'd0;
                            // Still low at mid start bit: real frame; else glitch.
                            if (!w_line) begin
                                r_state   <= DATA;
                                r_bit_idx <= 3'd0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd15) begin
                            r_tick_cnt <= 4'd0;
                            r_shift    <= {w_line, r_shift[7:1]};
                            if (r_bit_idx == 3'd7) begin
                                r_state <= STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd15) begin
                            // Leave at mid stop bit so a prompt next start is caught.
                            r_tick_cnt <= 4'd0;
                            r_state    <= IDLE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tick_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign w_stop_sample = (r_state == STOP) && w_tick && (r_tick_cnt == 4'd15);
    assign w_byte_ok     = w_stop_sample && w_line;
    assign w_byte_bad    = w_stop_sample && !w_line;
    assign w_rd_rxd      = rd && (addr == UART_RXD);
    assign w_wr_con      = wr && (addr == UART_CON);
    // A byte landing while the old one is being read is a hand-off, not an overrun.
    assign w_ovr_set     = w_byte_ok && r_rx_valid && !w_rd_rxd;

    // CPU-visible data and status registers; hardware set beats W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_int_en <= 1'b0;
        end else begin
            if (w_wr_con) begin
                r_rx_int_en <= wdata[CON_RX_INT_EN];
            end

            if (w_byte_ok) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_rxd) begin
                r_rx_valid <= 1'b0;
            end

            if (w_byte_bad) begin
                r_frame_err <= 1'b1;
            end else if (w_wr_con && wdata[CON_FRAME_ERR]) begin
                r_frame_err <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_wr_con && wdata[CON_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Read mux; bits 0 and 2 of UART_CON belong to the TX block and read 0 here.
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd) begin
            if (addr == UART_RXD) begin
                rdata = {24'h00_0000, r_rx_data};
            end else if (addr == UART_CON) begin
                rdata = {26'd0, r_overrun, r_frame_err, r_rx_valid,
                         1'b0, r_rx_int_en, 1'b0};
            end else begin
                rdata = 32'h0000_0000;
            end
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign irq = r_rx_valid && r_rx_int_en;

    assign w_unused = ^{wdata[31:6], wdata[3:2], wdata[0]};

endmodule

// File: tb/tb_uart_rx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_periph
// Self-checking bench: DIV = 1, so one bit = 16 clocks. Directed frame table,
// hand-written corner sequences, and random operations checked against a
// register-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_periph;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rxd = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int n_chk = 0;
    int n_pass = 0;

    uart_rx_periph #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop_ok;
        logic        do_read;
        logic [31:0] exp_con;
        logic [31:0] exp_rxd;
        logic [31:0] clr_w;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // All bus tasks are entered at a falling clock edge.
    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = 32'h0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (16) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    function automatic logic [31:0] con_word(input logic ov, input logic fe,
                                             input logic vl, input logic ie);
        return {26'd0, ov, fe, vl, 1'b0, ie, 1'b0};
    endfunction

    // Reference model of the CPU-visible state
    logic [7:0] m_data;
    logic m_valid, m_fe, m_ov, m_ie;

    logic [31:0] d;
    logic [31:0] w;
    logic [7:0]  b;
    int          op;
    int          lat;
    logic        seen;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h11, 1'b1, 1'b0, 32'h08, 32'h00, 32'h00};
        vecs[1] = '{8'h22, 1'b1, 1'b1, 32'h28, 32'h22, 32'h20};
        vecs[2] = '{8'h7E, 1'b0, 1'b0, 32'h10, 32'h00, 32'h10};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 32'h08, 32'h80, 32'h00};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 32'h10, 32'h00, 32'h10};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        cpu_read(A_CON, d); check("reset_con", d, 32'h0);
        cpu_read(A_RXD, d); check("reset_rxd", d, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        addr = 32'h4000_0000; rd = 1'b1; #1 check("unmapped_rd", rdata, 32'h0);
        @(negedge clk); rd = 1'b0; addr = 32'h0;

        // Frame 0x5A with latency measurement on the rx_valid bit
        lat = 0; seen = 1'b0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                addr = A_CON; rd = 1'b1;
                while (!seen && lat < 400) begin
                    @(negedge clk);
                    lat++;
                    if (rdata[3]) seen = 1'b1;
                end
                rd = 1'b0; addr = 32'h0;
            end
        join
        check($sformatf("latency_in_range n=%0d", lat),
              {31'd0, (seen && lat >= 153 && lat <= 155)}, 32'h1);
        cpu_read(A_CON, d); check("5a_valid_before", {31'd0, d[3]}, 32'h1);
        cpu_read(A_RXD, d); check("5a_rxd", d, 32'h5A);
        cpu_read(A_CON, d); check("5a_valid_after", {31'd0, d[3]}, 32'h0);

        // Directed frame table: overrun, frame error, W1C
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_ok);
            cpu_read(A_CON, d); check($sformatf("tbl%0d_con", i), d, vecs[i].exp_con);
            if (vecs[i].do_read) begin
                cpu_read(A_RXD, d); check($sformatf("tbl%0d_rxd", i), d, vecs[i].exp_rxd);
            end
            if (vecs[i].clr_w != 32'h0) cpu_write(A_CON, vecs[i].clr_w);
        end
        cpu_read(A_CON, d); check("tbl_final_con", d, 32'h0);

        // Interrupt: rises on landing, falls the cycle after the RXD read
        cpu_write(A_CON, 32'h2);
        check("irq_idle", {31'd0, irq}, 32'h0);
        send_frame(8'hC3, 1'b1);
        check("irq_set", {31'd0, irq}, 32'h1);
        addr = A_RXD; rd = 1'b1;
        #1 check("irq_rxd", rdata, 32'hC3);
        check("irq_during_read", {31'd0, irq}, 32'h1);
        @(negedge clk); rd = 1'b0; addr = 32'h0;
        check("irq_after_read", {31'd0, irq}, 32'h0);

        // Byte completes on the same edge as an RXD read: no overrun
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (154) @(negedge clk);
                addr = A_RXD; rd = 1'b1;
                #1 check("coinc_old_rxd", rdata, 32'h44);
                @(negedge clk);
                rd = 1'b0; addr = 32'h0;
            end
        join
        cpu_read(A_CON, d); check("coinc_con", d, 32'h0A);
        cpu_read(A_RXD, d); check("coinc_new_rxd", d, 32'h99);
        check("coinc_irq_after", {31'd0, irq}, 32'h0);
        cpu_write(A_CON, 32'h0);

        // Short glitch is rejected, next frame is received
        uart_rxd = 1'b0; repeat (4) @(negedge clk);
        uart_rxd = 1'b1; repeat (30) @(negedge clk);
        cpu_read(A_CON, d); check("glitch_con", d, 32'h0);
        send_frame(8'hA5, 1'b1);
        cpu_read(A_CON, d); check("glitch_next_con", d, 32'h08);
        cpu_read(A_RXD, d); check("glitch_next_rxd", d, 32'hA5);

        // Random operations against the reference model
        m_data = 8'hA5; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_ie = 1'b0;
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin
                    b = 8'($urandom);
                    send_frame(b, 1'b1);
                    if (m_valid) m_ov = 1'b1;
                    m_data = b; m_valid = 1'b1;
                end
                2: begin
                    b = 8'($urandom);
                    send_frame(b, 1'b0);
                    m_fe = 1'b1;
                end
                3, 4: begin
                    cpu_read(A_RXD, d);
                    check($sformatf("rnd%0d_rxd", it), d, {24'h0, m_data});
                    m_valid = 1'b0;
                end
                default: begin
                    w = $urandom;
                    cpu_write(A_CON, w);
                    m_ie = w[1];
                    if (w[4]) m_fe = 1'b0;
                    if (w[5]) m_ov = 1'b0;
                end
            endcase
            cpu_read(A_CON, d);
            check($sformatf("rnd%0d_con", it), d, con_word(m_ov, m_fe, m_valid, m_ie));
            check($sformatf("rnd%0d_irq", it), {31'd0, irq}, {31'd0, m_valid & m_ie});
        end

        // Reset during bit 4 of a frame abandons it
        cpu_write(A_CON, 32'h2);
        send_frame(8'h33, 1'b1);
        b = 8'h3C;
        uart_rxd = 1'b0; repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = b[i]; repeat (16) @(negedge clk);
        end
        uart_rxd = b[4]; repeat (8) @(negedge clk);
        reset = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'h0);
        cpu_read(A_CON, d); check("rst_con", d, 32'h0);
        cpu_read(A_RXD, d); check("rst_rxd", d, 32'h0);
        repeat (200) @(negedge clk);
        cpu_read(A_CON, d); check("rst_no_partial", d, 32'h0);
        send_frame(8'h0F, 1'b1);
        cpu_read(A_RXD, d); check("rst_next_rxd", d, 32'h0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_periph.md
# uart_rx_periph

Memory-mapped UART receiver peripheral for the single-cycle MIPS CPU's I/O space at 0x4000_0000. It is the receive-side counterpart of the UART transmit path that firmware drives through UART_TXD (0x4000_0018) and UART_CON (0x4000_0020). It deserialises 8N1 frames from the `uart_rxd` pin and exposes each byte in UART_RXD (0x4000_001C). It reports receive status and errors in UART_CON, and raises an interrupt request when a byte is waiting.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `BAUD`, 9600, line rate; oversampling divisor `DIV = CLK_FREQ/(BAUD*16)` (floor, minimum 1)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `uart_rxd`  in  1  serial input, asynchronous to `clk`, idles high
- `addr`  in  32  CPU data address
- `rd`  in  1  CPU MemRead
- `wr`  in  1  CPU MemWrite
- `wdata`  in  32  CPU store data
- `rdata`  out  32  read data; 0 when not selected
- `irq`  out  1  receive interrupt request

## Operation
- Register map. Full 32-bit address compare.
  - 0x4000_001C UART_RXD is read-only: `{24'b0, rx_data}`.
  - 0x4000_0020 UART_CON is read/write.
    - bit1 `rx_int_en`: R/W.
    - bit3 `rx_valid`: RO.
    - bit4 `frame_err`: R, write-1-clears.
    - bit5 `overrun`: R, write-1-clears.
    - All other bits read 0 and ignore writes. Bits 0 and 2 belong to the TX block; this block never drives them.
- `rdata` is combinational: selected register when `rd` is high and the address matches, else 0.
- Input path: `uart_rxd` passes through a 2-flop synchroniser; a 16× tick pulses once every `DIV` clocks while the FSM is out of IDLE.
- FSM:
  - IDLE: when the synchronised line is low, clear the tick counter and go to START.
  - START: at tick 7 (mid start bit), if the line is still low go to DATA with bit index 0; if high, go back to IDLE (glitch rejected, no error).
  - DATA: every 16 ticks, sample the line and shift it into the shift register LSB-first. After bit 7 go to STOP.
  - STOP: at mid stop bit, sample the line.
    - If high: load `rx_data` and set `rx_valid`. If `rx_valid` was already 1, also set `overrun`; the new byte replaces the old one.
    - If low: set `frame_err` and discard the byte.
    - In both cases go to IDLE.
- A read of UART_RXD (`rd` with matching address) clears `rx_valid` at the next clock edge.
- `irq = rx_valid & rx_int_en`, combinational from registers.
- Simultaneous events:
  - A byte completes on the same edge as a UART_RXD read: `rx_valid` stays 1, `rx_data` takes the new byte, `overrun` is not set.
  - A UART_CON write-1-clear coincides with an error being set: the set wins.
- Reset:
  - State IDLE; all counters 0; shift register 0.
  - `rx_data` = 0; `rx_valid`, `frame_err`, `overrun`, `rx_int_en` = 0.
  - `rdata` = 0; `irq` = 0.
  - Reset mid-frame abandons the frame. No partial byte is delivered.

## Timing
- Latency from a falling edge on the pin to `rx_valid` = 1: 2 synchroniser cycles + 152 ticks (8 + 16×8 + 16) × `DIV`, within ±`DIV` clocks.
- Samples fall at the mid-bit point of each bit.
- The FSM returns to IDLE at mid stop bit, so a back-to-back start edge half a bit later is caught.
- Register writes take effect on the clock edge where `wr` is high; `irq` updates in the same cycle.
- Tolerates ±3% baud mismatch.

## Structure
- Package `uart_pkg` holds:
  - address constants UART_TXD/UART_RXD/UART_CON;
  - UART_CON bit indices;
  - the `rx_state_t` enum {IDLE, START, DATA, STOP}.
- Sub-module `uart_baud_tick` (params `CLK_FREQ`, `BAUD`; ports `clk`, `reset`, `en`, `tick`) generates the 16× tick and restarts its count when `en` falls.
- Shift register, bit counter and CPU-side register file stay in the top module.

## Test plan
Run with `CLK_FREQ`=1_600_000 and `BAUD`=100_000, so `DIV`=1 and one bit = 16 clocks.
- Send frame 0x5A, then read 0x4000_001C → `rdata` = 0x0000_005A; UART_CON bit3 = 1 before the read and 0 after it.
- Write 0x2 to UART_CON, then send 0xC3 → `irq` rises when the byte lands and falls on the cycle after the RXD read.
- Send 0x11 then 0x22 with no read in between → RXD = 0x22, `overrun` = 1. Writing 0x20 to UART_CON clears `overrun`.
- Send a frame with the stop bit held low → `frame_err` = 1 and `rx_valid` = 0.
- Pull the pin low for 4 clocks, then return it high → FSM back in IDLE, no flags set, and a following frame 0xA5 is received correctly.
- Assert reset during bit 4 of a frame, then release → all registers 0, and the next full frame 0x0F reads back 0x0F.
